div_seq: RTL and testbench

- Sequential restoring divider for the ALU datapath; the inverse operation of the sequential multiplier.
- Same Init/Done start-and-complete handshake as the multiplier, so the ALU select logic can route it as a fourth operation.
- Computes the unsigned quotient and remainder of A / B, one quotient bit per clock.
- Flags division by zero instead of iterating.

---
 rtl/div_seq.sv | 133 +++++++++++++
 tb/tb_div_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
//
// Computes the unsigned quotient and remainder of A / B using the same
// Init/Done handshake as the sequential multiplier. A divisor of zero is
// flagged at once and never iterated.
//
// Ports:
//   Clk      rising-edge clock
//   Rst      asynchronous, active-high reset
//   Init     start request, sampled on rising Clk (ignored while Busy)
//   A, B     dividend and divisor, unsigned, latched on the start edge
//   Quot     registered quotient (all ones on divide by zero)
//   Rem      registered remainder (A on divide by zero)
//   Sal      {Rem, Quot}
//   DivZero  last operation had B == 0
//   Busy     iterating
//   Done     result valid, level until the next start
module div_seq #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Init,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   Quot,
  output logic [WIDTH-1:0]   Rem,
  output logic [2*WIDTH-1:0] Sal,
  output logic               DivZero,
  output logic               Busy,
  output logic               Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   r_q;      // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q;      // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] bq_q;     // divisor latched at start
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH+1:0] step;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The remainder's guard bit
  // is always 0 (remainder < divisor), but it is kept in the compare so the
  // trial value is exact. Returns {new remainder, quotient bit}.
  function automatic logic [WIDTH+1:0] div_step(input logic [WIDTH:0]   r,
                                                input logic             qbit,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH+1:0] t;
    t = {r, qbit};
    if (t >= {2'b00, d})
      return {(WIDTH+1)'(t - {2'b00, d}), 1'b1};
    else
      return {t[WIDTH:0], 1'b0};
  endfunction

  assign step   = div_step(r_q, q_q[WIDTH-1], bq_q);
  assign r_next = step[WIDTH+1:1];
  assign q_next = {q_q[WIDTH-2:0], step[0]};

  assign Sal = {Rem, Quot};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Init) state_d = (B == '0) ? FIN : CALC;
      end
      CALC: begin
        Busy = 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIN;
      end
      FIN: begin
        Done = 1'b1;
        if (Init) state_d = (B == '0) ? FIN : CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_q     <= '0;
      q_q     <= '0;
      bq_q    <= '0;
      cnt_q   <= '0;
      Quot    <= '0;
      Rem     <= '0;
      DivZero <= 1'b0;
    end else if (state_q == CALC) begin
      r_q   <= r_next;
      q_q   <= q_next;
      cnt_q <= cnt_q - CNT_LAST;
      if (cnt_q == CNT_LAST) begin
        Quot <= q_next;
        Rem  <= r_next[WIDTH-1:0];
      end
    end else if (Init) begin
      if (B == '0) begin
        Quot    <= '1;
        Rem     <= A;
        DivZero <= 1'b1;
      end else begin
        r_q     <= '0;
        q_q     <= A;
        bq_q    <= B;
        cnt_q   <= CNT_INIT;
        DivZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq (WIDTH = 4).
module tb_div_seq;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Init;
  logic [3:0] A, B;
  logic [3:0] Quot, Rem;
  logic [7:0] Sal;
  logic       DivZero, Busy, Done;

  int checks = 0;
  int errors = 0;
  int edges, busy_n, done_n;

  div_seq #(.WIDTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .Init(Init), .A(A), .B(B),
    .Quot(Quot), .Rem(Rem), .Sal(Sal), .DivZero(DivZero),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands and a one-cycle Init; returns at the falling edge
  // after the start edge (edge 1).
  task automatic start(input logic [3:0] a, input logic [3:0] b);
    @(negedge Clk);
    A = a; B = b; Init = 1'b1;
    @(negedge Clk);
    Init = 1'b0;
  endtask

  // Counts rising edges (start edge = 1) until Done, and Busy samples seen.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 1;
    n_busy  = 0;
    while (!Done && n_edges < 20) begin
      if (Busy) n_busy++;
      @(negedge Clk);
      n_edges++;
    end
    if (!Done) check("timeout", 32'(Done), 32'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input int exp_edges, input logic [3:0] eq, input logic [3:0] er,
                     input logic ez);
    start(a, b);
    wait_done(edges, busy_n);
    check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    check({tag, "_busy"},  32'(busy_n), 32'(exp_edges - 1));
    check({tag, "_quot"},  32'(Quot), 32'(eq));
    check({tag, "_rem"},   32'(Rem), 32'(er));
    check({tag, "_sal"},   32'(Sal), 32'({er, eq}));
    check({tag, "_dz"},    32'(DivZero), 32'(ez));
  endtask

  initial begin
    Rst = 1'b1; Init = 1'b0; A = '0; B = '0;
    #12;
    check("rst_quot", 32'(Quot), 0);
    check("rst_rem",  32'(Rem), 0);
    check("rst_sal",  32'(Sal), 0);
    check("rst_dz",   32'(DivZero), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    @(negedge Clk);
    Rst = 1'b0;

    run("d13_4",  4'd13, 4'd4,  5, 4'd3,  4'd1,  1'b0);
    run("d15_1",  4'd15, 4'd1,  5, 4'd15, 4'd0,  1'b0);
    run("d3_7",   4'd3,  4'd7,  5, 4'd0,  4'd3,  1'b0);
    run("d15_15", 4'd15, 4'd15, 5, 4'd1,  4'd0,  1'b0);
    run("d0_6",   4'd0,  4'd6,  5, 4'd0,  4'd0,  1'b0);
    run("dz9",    4'd9,  4'd0,  1, 4'hF,  4'd9,  1'b1);

    // Second Init and a new A during CALC must be ignored.
    start(4'd14, 4'd3);
    A = 4'd2; Init = 1'b1;
    @(negedge Clk);
    Init = 1'b0;
    check("ign_hold_quot", 32'(Quot), 32'hF);
    edges = 2;
    while (!Done && edges < 20) begin
      @(negedge Clk);
      edges++;
    end
    check("ign_edges", 32'(edges), 5);
    check("ign_quot",  32'(Quot), 4);
    check("ign_rem",   32'(Rem), 2);

    // Asynchronous reset between edges 2 and 3.
    start(4'd12, 4'd5);
    @(negedge Clk);
    check("mid_hold_quot", 32'(Quot), 4);
    check("mid_busy", 32'(Busy), 1);
    #2 Rst = 1'b1;
    #1;
    check("mid_rst_quot", 32'(Quot), 0);
    check("mid_rst_rem",  32'(Rem), 0);
    check("mid_rst_sal",  32'(Sal), 0);
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_done", 32'(Done), 0);
    @(negedge Clk);
    Rst = 1'b0;
    run("d12_5", 4'd12, 4'd5, 5, 4'd2, 4'd2, 1'b0);

    // Init held high: back-to-back runs, Done high one cycle per result.
    @(negedge Clk);
    A = 4'd6; B = 4'd3; Init = 1'b1;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Done) done_n++;
    end
    Init = 1'b0;
    check("b2b_done_cycles", 32'(done_n), 2);
    wait_done(edges, busy_n);
    check("b2b_quot", 32'(Quot), 2);
    check("b2b_rem",  32'(Rem), 0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start(4'(a), 4'(b));
        wait_done(edges, busy_n);
        if (b != 0) begin
          check("sweep_quot", 32'(Quot), 32'(a / b));
          check("sweep_rem",  32'(Rem), 32'(a % b));
          check("sweep_dz",   32'(DivZero), 0);
        end else begin
          check("sweep_z_dz",   32'(DivZero), 1);
          check("sweep_z_quot", 32'(Quot), 32'hF);
          check("sweep_z_rem",  32'(Rem), 32'(a));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
